abro_state_machine: RTL and testbench

//   ABRO controller (DUT name ABRO_StateMachine): waits until both A and B have been seen, in any

---
 rtl/abro_state_machine.sv | 108 ++++++++++
 tb/tb_abro_state_machine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/abro_state_machine.sv
`default_nettype none
// ============================================================================
//  Module      : abro_state_machine
//  Description : ABRO controller. Waits until both A and B have been seen
//                (in either order or together), then raises O. O holds
//                until the asynchronous active-low reset (the R event).
//                The one-hot state register is exported for debug.
//                Optional build macro ABRO_REARM_EN: DONE lasts a single
//                cycle (O becomes a 1-cycle pulse) and the machine re-arms
//                from the A/B sampled in that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module abro_state_machine (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       A,
    input  logic       B,
    output logic       O,
    output logic [3:0] State
);

    // One-hot state encoding; the exported State port shows these directly.
    localparam logic [3:0] c_IDLE  = 4'b0001;
    localparam logic [3:0] c_GOT_A = 4'b0010;
    localparam logic [3:0] c_GOT_B = 4'b0100;
    localparam logic [3:0] c_DONE  = 4'b1000;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_a;
    logic       w_b;
    logic       w_o;

    // Inputs may float (X/Z) before they are first driven; only a solid 1
    // counts as an event, so an undriven input behaves as "not seen".
    assign w_a = (A === 1'b1);
    assign w_b = (B === 1'b1);

    // State register: asynchronous reset returns to IDLE without a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; any non-one-hot value recovers to IDLE.
    always_comb begin
        w_next_state = c_IDLE;
        case (r_state)
            c_IDLE: begin
                if (w_a && w_b) begin
                    w_next_state = c_DONE;
                end else if (w_a) begin
                    w_next_state = c_GOT_A;
                end else if (w_b) begin
                    w_next_state = c_GOT_B;
                end else begin
                    w_next_state = c_IDLE;
                end
            end
            c_GOT_A: begin
                // Repeated A while waiting for B is ignored.
                w_next_state = w_b ? c_DONE : c_GOT_A;
            end
            c_GOT_B: begin
                // Repeated B while waiting for A is ignored.
                w_next_state = w_a ? c_DONE : c_GOT_B;
            end
            c_DONE: begin
`ifdef ABRO_REARM_EN
                // Re-arm: DONE lasts one cycle and the A/B sampled in it
                // are judged exactly as if the machine were in IDLE.
                if (w_a && w_b) begin
                    w_next_state = c_DONE;
                end else if (w_a) begin
                    w_next_state = c_GOT_A;
                end else if (w_b) begin
                    w_next_state = c_GOT_B;
                end else begin
                    w_next_state = c_IDLE;
                end
`else
                // Classic ABRO: DONE is sticky until reset_n asserts.
                w_next_state = c_DONE;
`endif
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // Output decode: O is a full compare on the state, not just bit 3, so
    // it can never be high for an illegal encoding.
    always_comb begin
        w_o = 1'b0;
        if (r_state == c_DONE) begin
            w_o = 1'b1;
        end
    end

    assign O     = w_o;
    assign State = r_state;

endmodule
`default_nettype wire

// File: tb/tb_abro_state_machine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_abro_state_machine
//  Description : Scoreboard bench for abro_state_machine. Stimulus drives
//                A/B on the falling edge and queues the hand-computed state
//                expected after the next rising edge; a monitor pops and
//                compares just after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_abro_state_machine;

    localparam logic [3:0] c_IDLE  = 4'b0001;
    localparam logic [3:0] c_GOT_A = 4'b0010;
    localparam logic [3:0] c_GOT_B = 4'b0100;
    localparam logic [3:0] c_DONE  = 4'b1000;

    logic       clk;
    logic       reset_n;
    logic       A;
    logic       B;
    logic       O;
    logic [3:0] State;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];

    abro_state_machine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .O       (O),
        .State   (State)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, required finish before 20000");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

    task automatic check_state(input string name, input logic [3:0] exp);
        tests_run++;
        if (State !== exp) begin
            tests_failed++;
            $display("FAIL %s: State=%b required %b", name, State, exp);
        end
        tests_run++;
        if (O !== (exp == c_DONE)) begin
            tests_failed++;
            $display("FAIL %s: O=%b required %b", name, O, (exp == c_DONE));
        end
    endtask

    // Monitor: every rising edge, O must match the DONE decode of State, and
    // any queued expectation is compared.
    always @(posedge clk) begin
        #1;
        tests_run++;
        if (O !== (State == c_DONE)) begin
            tests_failed++;
            $display("FAIL o_decode: O=%b required %b (State=%b)", O, (State == c_DONE), State);
        end
        if (exp_q.size() > 0) begin
            check_state("step", exp_q.pop_front());
        end
    end

    // Drive one A/B vector for one cycle and queue the expected result.
    task automatic step(input logic a, input logic b, input logic [3:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        exp_q.push_back(exp);
    endtask

    // Assert reset between edges and check it acts without a clock.
    task automatic async_reset(input string name);
        @(negedge clk);
        A = 1'b0;
        B = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_state(name, c_IDLE);
        @(negedge clk);
        check_state({name, "_hold"}, c_IDLE);
        reset_n = 1'b1;
    endtask

    // Pulse on A that starts after a rising edge and ends before the next.
    task automatic missed_pulse(input logic [3:0] exp);
        @(negedge clk);
        A = 1'b0;
        B = 1'b0;
        @(posedge clk);
        #2;
        A = 1'b1;
        #2;
        A = 1'b0;
        exp_q.push_back(exp);
        @(posedge clk);
    endtask

    initial begin
        reset_n = 1'b1;
        A = 1'bx;
        B = 1'bx;
        #2;
        reset_n = 1'b0;
        #1;
        check_state("reset_async_entry", c_IDLE);
        // Reset held for several cycles, with A/B undriven and then both high.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_state("reset_hold_x", c_IDLE);
        end
        A = 1'b1;
        B = 1'b1;
        @(negedge clk);
        check_state("reset_hold_ab", c_IDLE);
        A = 1'b0;
        B = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // A then B, then toggle inputs while in DONE.
        step(1'b1, 1'b0, c_GOT_A);
        step(1'b0, 1'b1, c_DONE);
`ifdef ABRO_REARM_EN
        step(1'b0, 1'b0, c_IDLE);
        step(1'b1, 1'b1, c_DONE);
        step(1'b1, 1'b0, c_GOT_A);
        step(1'b0, 1'b1, c_DONE);
        step(1'b0, 1'b1, c_GOT_B);
        step(1'b0, 1'b0, c_GOT_B);
`else
        step(1'b1, 1'b0, c_DONE);
        step(1'b0, 1'b1, c_DONE);
        step(1'b1, 1'b1, c_DONE);
        step(1'b0, 1'b0, c_DONE);
`endif
        async_reset("reset_after_seq1");

        // B first, repeated B ignored, then A.
        step(1'b0, 1'b1, c_GOT_B);
        step(1'b0, 1'b1, c_GOT_B);
        step(1'b1, 1'b0, c_DONE);
        async_reset("reset_in_done_ba");

        // A and B together from IDLE.
        step(1'b1, 1'b1, c_DONE);
        async_reset("reset_in_done_ab");

        // Hold A for several cycles in GOT_A, then B.
        step(1'b1, 1'b0, c_GOT_A);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, c_GOT_A);
        end
        step(1'b0, 1'b0, c_GOT_A);
        async_reset("reset_in_got_a");

        // Sub-cycle pulse that misses every rising edge is not registered.
        missed_pulse(c_IDLE);

        // Back to DONE once more after the mid-operation reset.
        step(1'b0, 1'b1, c_GOT_B);
        step(1'b1, 1'b1, c_DONE);
        step(1'b0, 1'b0, c_DONE_OR_REARM());
        @(negedge clk);
        A = 1'b0;
        B = 1'b0;
        @(negedge clk);

        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // State expected one cycle after DONE when A=B=0 are sampled.
    function automatic logic [3:0] c_DONE_OR_REARM();
`ifdef ABRO_REARM_EN
        return c_IDLE;
`else
        return c_DONE;
`endif
    endfunction

endmodule
`default_nettype wire
